// File: rtl/pattern_sequencer.sv
// Frame-synchronous scheduler: selects one pattern generator at a time and ramps its
// shared speed down, blanks, advances the selection, then ramps back up.
module pattern_sequencer #(
    parameter int NUM_PATTERNS = 4,
    parameter int SEL_W        = 2,
    parameter int DWELL_FRAMES = 600,
    parameter int BLANK_FRAMES = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    next_frame,
    input  logic                    btn_next,
    input  logic                    auto_en,
    input  logic [2:0]              speed_max,
    output logic [SEL_W-1:0]        pattern_sel,
    output logic [NUM_PATTERNS-1:0] pattern_enable,
    output logic [2:0]              step_size,
    output logic                    blank,
    output logic [1:0]              state
);

    // state     | meaning
    // RAMP_UP   | step_size climbs toward speed_max, one step per frame
    // RUN       | step_size follows speed_max; waits for a button or dwell timeout
    // RAMP_DOWN | step_size falls to 0, one step per frame
    // BLANK     | output forced black for BLANK_FRAMES frames, then selection advances
    localparam logic [1:0] S_RAMP_UP   = 2'd0;
    localparam logic [1:0] S_RUN       = 2'd1;
    localparam logic [1:0] S_RAMP_DOWN = 2'd2;
    localparam logic [1:0] S_BLANK     = 2'd3;

    localparam logic [15:0]      DWELL_LAST = 16'(DWELL_FRAMES - 1);
    localparam logic [7:0]       BLANK_LAST = 8'(BLANK_FRAMES - 1);
    localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(NUM_PATTERNS - 1);

    logic [1:0]              state_q, state_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [NUM_PATTERNS-1:0] en_q, en_d;
    logic [2:0]              step_q, step_d;
    logic                    blank_q, blank_d;
    logic [15:0]             dwell_q, dwell_d;
    logic [7:0]              bcnt_q, bcnt_d;
    logic                    pending_q, pending_d;
    logic                    trig;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        step_d    = step_q;
        blank_d   = blank_q;
        dwell_d   = dwell_q;
        bcnt_d    = bcnt_q;
        pending_d = pending_q;
        trig      = pending_q | btn_next | (auto_en & (dwell_q == DWELL_LAST));

        // A button between frames is remembered so it is acted on at the next frame.
        if (btn_next && (state_q == S_RAMP_UP || (state_q == S_RUN && !next_frame)))
            pending_d = 1'b1;

        if (next_frame) begin
            case (state_q)
                S_RAMP_UP: begin
                    if (step_q < speed_max) begin
                        step_d = step_q + 3'd1;
                    end else begin
                        state_d = S_RUN;
                        step_d  = speed_max;
                        dwell_d = '0;
                    end
                end
                S_RUN: begin
                    step_d = speed_max;
                    if (trig) begin
                        state_d   = S_RAMP_DOWN;
                        dwell_d   = '0;
                        pending_d = 1'b0;
                    end else if (auto_en && dwell_q != 16'hFFFF) begin
                        dwell_d = dwell_q + 16'd1;
                    end
                end
                S_RAMP_DOWN: begin
                    if (step_q != 3'd0) begin
                        step_d = step_q - 3'd1;
                    end else begin
                        state_d = S_BLANK;
                        blank_d = 1'b1;
                        bcnt_d  = '0;
                    end
                end
                default: begin
                    bcnt_d = bcnt_q + 8'd1;
                    if (bcnt_q == BLANK_LAST) begin
                        sel_d   = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
                        blank_d = 1'b0;
                        state_d = S_RAMP_UP;
                    end
                end
            endcase
        end

        for (int i = 0; i < NUM_PATTERNS; i++)
            en_d[i] = (32'(sel_d) == i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_RAMP_UP;
            sel_q     <= '0;
            en_q      <= NUM_PATTERNS'(1);
            step_q    <= '0;
            blank_q   <= 1'b0;
            dwell_q   <= '0;
            bcnt_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            en_q      <= en_d;
            step_q    <= step_d;
            blank_q   <= blank_d;
            dwell_q   <= dwell_d;
            bcnt_q    <= bcnt_d;
            pending_q <= pending_d;
        end
    end

    assign pattern_sel    = sel_q;
    assign pattern_enable = en_q;
    assign step_size      = step_q;
    assign blank          = blank_q;
    assign state          = state_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer: ramps, button/dwell advances, wrap, live speed, reset.
module tb_pattern_sequencer;

    logic       clk = 1'b0;
    logic       rst, next_frame, btn_next, auto_en;
    logic [2:0] speed_max;
    logic [1:0] pattern_sel;
    logic [3:0] pattern_enable;
    logic [2:0] step_size;
    logic       blank;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    pattern_sequencer #(
        .NUM_PATTERNS(4),
        .SEL_W(2),
        .DWELL_FRAMES(4),
        .BLANK_FRAMES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .next_frame(next_frame),
        .btn_next(btn_next),
        .auto_en(auto_en),
        .speed_max(speed_max),
        .pattern_sel(pattern_sel),
        .pattern_enable(pattern_enable),
        .step_size(step_size),
        .blank(blank),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Each call starts and ends on a falling edge; outputs are then settled.
    task automatic pulse(input int n);
        for (int k = 0; k < n; k++) begin
            next_frame = 1'b1;
            @(negedge clk);
            next_frame = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic press();
        btn_next = 1'b1;
        @(negedge clk);
        btn_next = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; next_frame = 1'b0; btn_next = 1'b0; auto_en = 1'b0; speed_max = 3'd3;
        repeat (2) @(negedge clk);
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_sel", 16'(pattern_sel), 16'd0);
        chk("rst_en", 16'(pattern_enable), 16'b0001);
        chk("rst_step", 16'(step_size), 16'd0);
        chk("rst_blank", 16'(blank), 16'd0);
        rst = 1'b0;

        // 1: ramp up to speed_max=3
        pulse(1); chk("up1_step", 16'(step_size), 16'd1); chk("up1_state", 16'(state), 16'd0);
        pulse(1); chk("up2_step", 16'(step_size), 16'd2);
        pulse(1); chk("up3_step", 16'(step_size), 16'd3); chk("up3_state", 16'(state), 16'd0);
        pulse(1); chk("up4_step", 16'(step_size), 16'd3); chk("up4_state", 16'(state), 16'd1);
        pulse(1); chk("run_state", 16'(state), 16'd1); chk("run_sel", 16'(pattern_sel), 16'd0);
        chk("run_blank", 16'(blank), 16'd0);

        // 2: button between frames waits for the next frame
        press();
        repeat (3) @(negedge clk);
        chk("btn_hold_state", 16'(state), 16'd1);
        chk("btn_hold_step", 16'(step_size), 16'd3);
        pulse(1); chk("rd_enter", 16'(state), 16'd2); chk("rd_step3", 16'(step_size), 16'd3);
        pulse(1); chk("rd_step2", 16'(step_size), 16'd2);
        pulse(1); chk("rd_step1", 16'(step_size), 16'd1);
        pulse(1); chk("rd_step0", 16'(step_size), 16'd0); chk("rd_state", 16'(state), 16'd2);
        pulse(1); chk("blank_enter", 16'(state), 16'd3); chk("blank_on", 16'(blank), 16'd1);
        pulse(7); chk("blank_7", 16'(blank), 16'd1); chk("blank_7_sel", 16'(pattern_sel), 16'd0);
        chk("blank_7_en", 16'(pattern_enable), 16'b0001);
        pulse(1); chk("blank_off", 16'(blank), 16'd0); chk("adv_sel1", 16'(pattern_sel), 16'd1);
        chk("adv_en1", 16'(pattern_enable), 16'b0010); chk("adv_state", 16'(state), 16'd0);

        // 3: auto advance after 4 frames in RUN, wrap from 3 to 0
        auto_en = 1'b1;
        pulse(4); chk("auto_run", 16'(state), 16'd1);
        pulse(3); chk("auto_dwell3", 16'(state), 16'd1);
        pulse(1); chk("auto_rd", 16'(state), 16'd2);
        pulse(12); chk("auto_sel2", 16'(pattern_sel), 16'd2); chk("auto_en2", 16'(pattern_enable), 16'b0100);
        pulse(8); chk("auto_rd2", 16'(state), 16'd2);
        pulse(12); chk("auto_sel3", 16'(pattern_sel), 16'd3);
        pulse(8);
        pulse(12); chk("wrap_sel0", 16'(pattern_sel), 16'd0); chk("wrap_en0", 16'(pattern_enable), 16'b0001);
        chk("wrap_state", 16'(state), 16'd0);

        // 4: button in RAMP_UP is remembered; in RAMP_DOWN/BLANK it is dropped
        auto_en = 1'b0;
        pulse(1);
        press();
        pulse(3); chk("pend_run", 16'(state), 16'd1);
        pulse(1); chk("pend_rd", 16'(state), 16'd2);
        pulse(1);
        press();
        pulse(3); chk("drop_blank", 16'(state), 16'd3);
        press();
        btn_next = 1'b1; next_frame = 1'b1;
        @(negedge clk);
        btn_next = 1'b0; next_frame = 1'b0;
        @(negedge clk);
        pulse(7); chk("one_adv_sel", 16'(pattern_sel), 16'd1); chk("one_adv_state", 16'(state), 16'd0);
        pulse(4); chk("one_adv_run", 16'(state), 16'd1);
        pulse(3); chk("no_extra_adv", 16'(state), 16'd1); chk("no_extra_sel", 16'(pattern_sel), 16'd1);

        // 5: live speed tracking in RUN
        speed_max = 3'd1;
        repeat (2) @(negedge clk);
        chk("spd_hold", 16'(step_size), 16'd3);
        pulse(1); chk("spd_down", 16'(step_size), 16'd1);
        speed_max = 3'd5;
        pulse(1); chk("spd_up", 16'(step_size), 16'd5);
        speed_max = 3'd3;
        pulse(1); chk("spd_back", 16'(step_size), 16'd3);

        // 6: reset during BLANK with pattern_sel=2
        press();
        pulse(1); chk("r6_rd", 16'(state), 16'd2);
        pulse(4); chk("r6_blank", 16'(state), 16'd3);
        pulse(8); chk("r6_sel2", 16'(pattern_sel), 16'd2);
        pulse(4); chk("r6_run", 16'(state), 16'd1);
        press();
        pulse(5);
        pulse(3); chk("r6_blank2", 16'(blank), 16'd1); chk("r6_blank2_sel", 16'(pattern_sel), 16'd2);
        rst = 1'b1; next_frame = 1'b1;
        @(negedge clk);
        next_frame = 1'b0;
        chk("r6_sel", 16'(pattern_sel), 16'd0);
        chk("r6_en", 16'(pattern_enable), 16'b0001);
        chk("r6_blank_off", 16'(blank), 16'd0);
        chk("r6_step", 16'(step_size), 16'd0);
        chk("r6_state", 16'(state), 16'd0);

        // speed_max=0 from reset reaches RUN on the first frame
        speed_max = 3'd0;
        @(negedge clk);
        rst = 1'b0;
        pulse(1); chk("zero_run", 16'(state), 16'd1); chk("zero_step", 16'(step_size), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
